// File: rtl/apb_protocol_top.sv
// APB subsystem: one master FSM, a 64-word register memory slave and a UART slave.
// A UART write sends the word as four 8N1 frames. Bytes received on rx are assembled into a readable word.
module apb_protocol_top #(
    parameter int CLKS_PER_BIT = 5,
    parameter int MEM_DEPTH    = 64
) (
    input  logic        pclk,
    input  logic        Reset,
    input  logic        penable,
    input  logic        pwrite,
    input  logic        transfer,
    input  logic [31:0] write_paddr,
    input  logic [31:0] apb_read_paddr,
    input  logic [31:0] write_data,
    input  logic [1:0]  Psel,
    output logic [31:0] apb_read_data_out,
    output logic [3:0]  PSTRB,
    input  logic        rx
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    apb_state_t r_state, w_next_state;
    logic        r_pwrite;
    logic [1:0]  r_psel;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        w_latch;
    logic        w_complete;
    logic        w_pready;
    logic [AW-1:0] w_idx;

    logic [31:0] r_mem [MEM_DEPTH];

    logic          r_tx;
    logic          r_tx_busy;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic [1:0]    r_tx_byte;
    logic [8:0]    r_tx_frame;
    logic [23:0]   r_tx_word;
    logic          w_tx_start;

    rx_state_t r_rx_state, w_rx_next;
    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [31:0]   r_rx_word;
    logic          w_rx_tick;

    logic w_unused;

    assign w_idx = r_paddr[AW+1:2];

    // Only a UART write stalls; memory, UART read and the empty select are zero-wait.
    assign w_pready = (r_psel == 2'b10 && r_pwrite) ? ~r_tx_busy : 1'b1;

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (transfer && penable) begin
                    w_next_state = ST_SETUP;
                    w_latch      = 1'b1;
                end
            end
            ST_SETUP: w_next_state = ST_ACCESS;
            ST_ACCESS: begin
                if (w_pready) begin
                    w_complete = 1'b1;
                    if (transfer && penable) begin
                        w_next_state = ST_SETUP;
                        w_latch      = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!Reset) begin
            r_state  <= ST_IDLE;
            r_pwrite <= 1'b0;
            r_psel   <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_pwrite <= pwrite;
                r_psel   <= Psel;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (w_latch) begin
            r_paddr  <= pwrite ? write_paddr : apb_read_paddr;
            r_pwdata <= write_data;
        end
    end

    assign PSTRB = (r_state != ST_IDLE && r_pwrite) ? 4'b1111 : 4'b0000;

    always_ff @(posedge pclk) begin
        if (!Reset) begin
            apb_read_data_out <= '0;
        end else if (w_complete && !r_pwrite) begin
            case (r_psel)
                2'b01:   apb_read_data_out <= r_mem[w_idx];
                2'b10:   apb_read_data_out <= r_rx_word;
                default: apb_read_data_out <= '0;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!Reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_complete && r_pwrite && r_psel == 2'b01) begin
            r_mem[w_idx] <= r_pwdata;
        end
    end

    // TX starts on the SETUP->ACCESS edge so busy is already high in the first ACCESS cycle.
    assign w_tx_start = (r_state == ST_SETUP) && (r_psel == 2'b10) && r_pwrite && !r_tx_busy;

    always_ff @(posedge pclk) begin
        if (!Reset) begin
            r_tx      <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_byte <= '0;
        end else if (w_tx_start) begin
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_tx_frame <= {1'b1, r_pwdata[7:0]};
            r_tx_word  <= r_pwdata[31:8];
        end else if (r_tx_busy) begin
            if (r_tx_cnt == CNT_MAX) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    if (r_tx_byte == 2'd3) begin
                        r_tx_busy <= 1'b0;
                        r_tx      <= 1'b1;
                    end else begin
                        r_tx_byte  <= r_tx_byte + 2'd1;
                        r_tx_bit   <= '0;
                        r_tx       <= 1'b0;
                        r_tx_frame <= {1'b1, r_tx_word[7:0]};
                        r_tx_word  <= {8'h00, r_tx_word[23:8]};
                    end
                end else begin
                    r_tx_bit   <= r_tx_bit + 4'd1;
                    r_tx       <= r_tx_frame[0];
                    r_tx_frame <= {1'b0, r_tx_frame[8:1]};
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end
    end

    // The start bit is re-checked at its middle; every later sample lands one bit period on.
    assign w_rx_tick = (r_rx_cnt == ((r_rx_state == RX_START) ? CNT_MID : CNT_MAX));

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (!r_rx_s2 && r_rx_s3) w_rx_next = RX_START;
            RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!Reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_word  <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            if (r_rx_state == RX_IDLE || w_rx_tick) r_rx_cnt <= '0;
            else r_rx_cnt <= r_rx_cnt + CW'(1);
            if (r_rx_state == RX_START) r_rx_bit <= '0;
            if (r_rx_state == RX_DATA && w_rx_tick) begin
                r_rx_bit   <= r_rx_bit + 3'd1;
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            end
            if (r_rx_state == RX_STOP && w_rx_tick && r_rx_s2) begin
                r_rx_word <= {r_rx_shift, r_rx_word[31:8]};
            end
        end
    end

    // Address bits outside the word index and the internal TX line have no reader in this block.
    assign w_unused = ^{r_paddr[31:AW+2], r_paddr[1:0], r_tx};

endmodule

// File: tb/tb_apb_protocol_top.sv
// Randomized bench for apb_protocol_top against a transaction-level model of memory, RX word and transfer timing.
module tb_apb_protocol_top;

    localparam int CLKS        = 5;
    localparam int UART_WR_CYC = 40 * CLKS + 2;

    logic        pclk = 1'b0;
    logic        Reset;
    logic        penable, pwrite, transfer, rx;
    logic [31:0] write_paddr, apb_read_paddr, write_data;
    logic [1:0]  Psel;
    logic [31:0] apb_read_data_out;
    logic [3:0]  PSTRB;

    always #5 pclk = ~pclk;

    apb_protocol_top #(.CLKS_PER_BIT(CLKS), .MEM_DEPTH(64)) dut (
        .pclk(pclk), .Reset(Reset), .penable(penable), .pwrite(pwrite),
        .transfer(transfer), .write_paddr(write_paddr), .apb_read_paddr(apb_read_paddr),
        .write_data(write_data), .Psel(Psel), .apb_read_data_out(apb_read_data_out),
        .PSTRB(PSTRB), .rx(rx)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int          n_err = 0;
    int          n_chk = 0;
    bit          chk_en = 1'b0;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_pstrb;
    logic [31:0] m_mem [64];
    logic [31:0] m_rx;
    logic [7:0]  tx_got [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (chk_en) begin
            chk("rdata", apb_read_data_out, exp_rdata);
            chk("pstrb", {28'h0, PSTRB}, {28'h0, exp_pstrb});
        end
    end

    function automatic txn_t mk(input logic [1:0] s, input logic w, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.sel = s; t.wr = w; t.addr = a; t.data = d;
        return t;
    endfunction

    function automatic logic [31:0] model_read(input txn_t t);
        case (t.sel)
            2'b01:   return m_mem[t.addr[7:2]];
            2'b10:   return m_rx;
            default: return 32'h0;
        endcase
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.sel  = 2'($urandom_range(0, 3));
        t.wr   = (t.sel == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1));
        t.addr = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        t.data = $urandom;
        return t;
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_req(input txn_t t);
        Psel       = t.sel;
        pwrite     = t.wr;
        write_data = t.data;
        if (t.wr) begin
            write_paddr    = t.addr;
            apb_read_paddr = $urandom;
        end else begin
            apb_read_paddr = t.addr;
            write_paddr    = $urandom;
        end
        transfer = 1'b1;
        penable  = 1'b1;
    endtask

    task automatic scramble();
        Psel           = 2'($urandom_range(0, 3));
        pwrite         = 1'($urandom_range(0, 1));
        write_paddr    = $urandom;
        apb_read_paddr = $urandom;
        write_data     = $urandom;
        penable        = 1'($urandom_range(0, 1));
        transfer       = 1'($urandom_range(0, 1));
    endtask

    // Called just after the edge that entered SETUP; returns just after the completion edge.
    task automatic do_txn(input txn_t t, input bit chain, input txn_t nx);
        int dur;
        dur = (t.sel == 2'b10 && t.wr) ? UART_WR_CYC : 2;
        exp_pstrb = t.wr ? 4'hF : 4'h0;
        step();
        if (dur > 2) begin
            scramble();
            repeat (dur - 2) step();
        end
        if (chain) drive_req(nx);
        else begin
            scramble();
            transfer = 1'b0;
        end
        step();
        exp_pstrb = 4'h0;
        if (t.wr) begin
            if (t.sel == 2'b01) m_mem[t.addr[7:2]] = t.data;
        end else begin
            exp_rdata = model_read(t);
        end
    endtask

    task automatic single(input txn_t t);
        drive_req(t);
        step();
        do_txn(t, 1'b0, t);
    endtask

    task automatic decode_tx();
        logic [7:0] b;
        int w;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (dut.r_tx !== 1'b0 && w < 400) begin
                @(negedge pclk);
                w++;
            end
            if (w >= 400) begin
                n_chk++;
                n_err++;
                $display("FAIL tx_start_timeout: byte %0d never started, required start within 400 cycles", k);
                return;
            end
            repeat ((CLKS - 1) / 2) @(negedge pclk);
            chk("tx_start_bit", {31'h0, dut.r_tx}, 32'h0);
            for (int i = 0; i < 8; i++) begin
                repeat (CLKS) @(negedge pclk);
                b[i] = dut.r_tx;
            end
            repeat (CLKS) @(negedge pclk);
            chk("tx_stop_bit", {31'h0, dut.r_tx}, 32'h1);
            tx_got[k] = b;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CLKS) step();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) step();
        end
        rx = stop;
        repeat (CLKS) step();
        rx = 1'b1;
        repeat (2 * CLKS) step();
        if (stop) m_rx = {b, m_rx[31:8]};
    endtask

    initial begin
        repeat (60000) @(posedge pclk);
        $display("FAIL watchdog: simulation still running after 60000 cycles, required to finish");
        $fatal(1, "timeout");
    end

    initial begin
        txn_t t, cur, nxt;
        bit   ch;

        Reset = 1'b0; rx = 1'b1; transfer = 1'b0; penable = 1'b0; pwrite = 1'b0;
        Psel = 2'b00; write_paddr = '0; apb_read_paddr = '0; write_data = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_rx = '0;
        exp_rdata = '0;
        exp_pstrb = '0;
        tx_got = '{default: 8'h00};
        repeat (2) @(posedge pclk);
        #1;
        chk_en = 1'b1;
        chk("reset_rdata", apb_read_data_out, 32'h0);
        Reset = 1'b1;
        repeat (5) step();

        // Memory write then read of the same word.
        single(mk(2'b01, 1'b1, 32'h0000_0008, 32'hCAFE_BABE));
        single(mk(2'b01, 1'b0, 32'h0000_0008, 32'h0));
        chk("mem_readback", apb_read_data_out, 32'hCAFE_BABE);

        // Random memory / empty-select / UART-read traffic, some back to back.
        cur = rand_txn();
        drive_req(cur);
        step();
        for (int i = 0; i < 40; i++) begin
            nxt = rand_txn();
            ch  = (i < 39) && ($urandom_range(0, 1) == 1);
            do_txn(cur, ch, nxt);
            if (!ch) begin
                repeat ($urandom_range(0, 2)) step();
                if (i < 39) begin
                    drive_req(nxt);
                    step();
                end
            end
            cur = nxt;
        end

        // penable low holds the FSM in IDLE even with a write request pending.
        Psel = 2'b10; transfer = 1'b1; penable = 1'b0; pwrite = 1'b1;
        repeat (50) step();
        t = mk(2'b10, 1'b1, 32'h0011_1111, 32'hDEAD_2023);
        drive_req(t);
        step();
        fork
            do_txn(t, 1'b0, t);
            decode_tx();
        join
        for (int k = 0; k < 4; k++) chk("tx_byte_model", {24'h0, tx_got[k]}, {24'h0, t.data[8*k +: 8]});
        chk("tx_byte0", {24'h0, tx_got[0]}, 32'h23);
        chk("tx_byte3", {24'h0, tx_got[3]}, 32'hDE);

        // RX assembly.
        repeat (3) step();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        single(mk(2'b10, 1'b0, $urandom, 32'h0));
        chk("rx_word", apb_read_data_out, 32'h4433_2211);

        // Short glitch and a bad-stop frame leave the word alone.
        rx = 1'b0;
        repeat (2) step();
        rx = 1'b1;
        repeat (20) step();
        send_byte(8'h55, 1'b0);
        single(mk(2'b10, 1'b0, $urandom, 32'h0));
        chk("rx_word_kept", apb_read_data_out, 32'h4433_2211);

        // Reset in the middle of a UART write.
        t = mk(2'b10, 1'b1, 32'h0, $urandom);
        drive_req(t);
        step();
        exp_pstrb = 4'hF;
        repeat (60) step();
        Reset = 1'b0; transfer = 1'b0; penable = 1'b0;
        step();
        exp_pstrb = 4'h0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_rx = '0;
        chk("tx_idle_after_reset", {31'h0, dut.r_tx}, 32'h1);
        Reset = 1'b1;
        repeat (3) step();
        single(mk(2'b01, 1'b0, 32'h0000_0008, 32'h0));
        chk("mem_cleared", apb_read_data_out, 32'h0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_protocol_top.md
Name: apb_protocol_top

Overview:
- Self-contained APB subsystem: one APB master FSM driving two APB slaves over an internal bus.
- Slave 1 is a 64-word register memory.
- Slave 2 is a UART peripheral. An APB write serializes the 32-bit word on an internal TX line (4 bytes, 8N1). Bytes received on `rx` assemble into a readable 32-bit word.
- Used as the top of the APB bus architecture; user-side signals request transfers.

Parameters:
- CLKS_PER_BIT, 5, pclk cycles per UART bit (one byte frame = 10*CLKS_PER_BIT cycles).
- MEM_DEPTH, 64, words in slave 1 memory (index = paddr[7:2]).

Ports:
- pclk  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-low reset.
- penable  input  1  master enable; FSM leaves IDLE only while high.
- pwrite  input  1  1 = write transfer, 0 = read transfer.
- transfer  input  1  transfer request.
- write_paddr  input  32  address for write transfers.
- apb_read_paddr  input  32  address for read transfers.
- write_data  input  32  write data.
- Psel  input  2  slave select: 01 = memory slave, 10 = UART slave, 00/11 = no slave.
- apb_read_data_out  output  32  registered read data.
- PSTRB  output  4  byte strobes on the internal bus.
- rx  input  1  UART serial input, idle high.

Behaviour:
- Reset (Reset==0 at a rising pclk edge) clears the following:
  - FSM to IDLE, apb_read_data_out=0, PSTRB=0.
  - Memory contents to 0.
  - UART TX idle: tx=1, busy=0.
  - UART RX idle, received word = 0, byte counter = 0.
- Master FSM states:
  - IDLE: if transfer && penable, go to SETUP; else stay.
  - SETUP (PSEL asserted, internal PENABLE=0): latch pwrite, address (write_paddr if pwrite else apb_read_paddr), write_data and Psel; go to ACCESS next cycle.
  - ACCESS (internal PENABLE=1): hold the latched signals until PREADY=1. On the PREADY cycle the transfer completes; go to SETUP if transfer && penable, else IDLE.
  - Minimum transfer is 2 cycles (zero-wait slave).
- PSTRB = 4'b1111 in SETUP/ACCESS of a write, 4'b0000 otherwise.
- Memory slave:
  - PREADY always 1.
  - Write: mem[paddr[7:2]] <= data at completion.
  - Read: returns mem[paddr[7:2]].
  - Upper address bits ignored (wrap).
- UART slave, write:
  - Entering ACCESS with TX idle starts transmission of data[7:0], [15:8], [23:16], [31:24] in that order.
  - Each byte frame is start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts CLKS_PER_BIT cycles.
  - PREADY stays 0 until the last stop bit ends, so a write takes 4*10*CLKS_PER_BIT (+2) cycles = 202 cycles at default.
- UART slave, read:
  - PREADY=1 immediately; returns the assembled RX word.
- UART RX:
  - A falling edge on rx (after a 2-flop synchronizer) starts a frame.
  - Start bit is re-checked at mid-bit; a false start returns to idle.
  - Data is sampled mid-bit, LSB first.
  - Each completed frame shifts the received byte into the word: word <= {byte, word[31:8]}.
  - A bad stop bit (0) discards the byte.
  - RX runs independently of APB state.
- Psel 00/11 (no slave): PREADY=1; writes discarded; read data = 0.
- apb_read_data_out updates only on completion of a read; it holds its value at all other times, including during writes.
- Changes to input signals during ACCESS are ignored until the next SETUP.
- Reset asserted mid-transfer (including a UART transmission) aborts it immediately: tx=1, FSM to IDLE.
- transfer or penable dropping during ACCESS does not abort; the transfer completes.

Test Plan:
- Reset=0 for 2 cycles, then 1 -> apb_read_data_out=0, PSTRB=0, FSM IDLE, no activity with transfer=0.
- Psel=01, write 0xCAFEBABE to 0x08, then read 0x08 -> write completes in 2 cycles with PSTRB=1111 during it; apb_read_data_out=0xCAFEBABE two cycles after read SETUP.
- Psel=10, transfer=1, penable=0 for 50 cycles -> FSM stays IDLE; then penable=1, pwrite=1, write_data=0xDEAD2023, write_paddr=0x00111111 -> internal tx frames are 0x23, 0x20, 0xAD, 0xDE, each 50 cycles; PREADY after 200 TX cycles.
- Drive rx with frames 0x11, 0x22, 0x33, 0x44 at 5 cycles/bit, then Psel=10 read -> apb_read_data_out=0x44332211.
- rx low glitch of 2 cycles, then a frame with stop bit 0 -> RX word unchanged.
- Reset low mid UART write -> tx=1 and FSM IDLE after that edge; a following memory read returns 0.
